// File: rtl/instr_mem_pkg.sv
// Shared types and constants for the instruction memory: FSM state encoding,
// half-select values and the instruction/word widths.
package instr_mem_pkg;

  localparam int INSTR_W = 32;
  localparam int WORD_W  = 64;

  // Instruction index bit 0 selects the half of the 64-bit word
  localparam logic HI_HALF = 1'b0;
  localparam logic LO_HALF = 1'b1;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_IDLE  = 2'd1,
    ST_LOAD  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/instr_mem_array.sv
// 2^ADDR_WIDTH x 64-bit storage: asynchronous read, synchronous write with an
// independent enable for each 32-bit half. Contents are never reset.
module instr_mem_array
  import instr_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  we_hi,
  input  logic                  we_lo,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [WORD_W-1:0]     wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [WORD_W-1:0]     rdata
);

  logic [WORD_W-1:0] mem_q [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (we_hi) mem_q[waddr][WORD_W-1:INSTR_W] <= wdata[WORD_W-1:INSTR_W];
    if (we_lo) mem_q[waddr][INSTR_W-1:0]      <= wdata[INSTR_W-1:0];
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/instr_mem.sv
// Instruction memory top: combinational fetch read port plus a 32-bit streaming
// load FSM. Define INSTR_MEM_CLEAR_EN to zero the whole array after reset.
//
// state    | meaning
// CLEAR    | post-reset sweep writing zero to every word (INSTR_MEM_CLEAR_EN only)
// IDLE     | waiting for ld_start
// LOAD     | accepting beats, one instruction half per accepted beat
// DONE     | one-cycle completion pulse
module instr_mem
  import instr_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_re,
  output logic [WORD_W-1:0]     mem_rdata,
  input  logic                  ld_start,
  input  logic [63:0]           ld_base,
  input  logic [ADDR_WIDTH+1:0] ld_len,
  input  logic                  ld_valid,
  input  logic [INSTR_W-1:0]    ld_data,
  output logic                  ld_ready,
  output logic                  busy,
  output logic                  done
);

  localparam int IDX_W = ADDR_WIDTH + 1;
  localparam int LEN_W = ADDR_WIDTH + 2;
  localparam logic [IDX_W-1:0] PTR_ONE = 1;
  localparam logic [LEN_W-1:0] REM_ONE = 1;

`ifdef INSTR_MEM_CLEAR_EN
  localparam state_e RST_STATE = ST_CLEAR;
`else
  localparam state_e RST_STATE = ST_IDLE;
`endif

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    ptr_q, ptr_d;
  logic [LEN_W-1:0]    rem_q, rem_d;
  logic                we_hi, we_lo;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [WORD_W-1:0]   wdata;
  logic [WORD_W-1:0]   rdata;
  logic                unused_base;

  assign unused_base = ^{ld_base[63:ADDR_WIDTH+3], ld_base[1:0]};

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    rem_d   = rem_q;
    we_hi   = 1'b0;
    we_lo   = 1'b0;
    waddr   = ptr_q[IDX_W-1:1];
    wdata   = {ld_data, ld_data};
    case (state_q)
`ifdef INSTR_MEM_CLEAR_EN
      // During the sweep ptr counts words rather than instruction indices
      ST_CLEAR: begin
        we_hi = 1'b1;
        we_lo = 1'b1;
        waddr = ptr_q[ADDR_WIDTH-1:0];
        wdata = '0;
        ptr_d = ptr_q + PTR_ONE;
        if (ptr_q[ADDR_WIDTH-1:0] == '1) begin
          ptr_d   = '0;
          state_d = ST_IDLE;
        end
      end
`endif
      ST_IDLE: begin
        if (ld_start) begin
          if (ld_len == '0) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_LOAD;
            ptr_d   = ld_base[ADDR_WIDTH+2:2];
            rem_d   = ld_len;
          end
        end
      end
      ST_LOAD: begin
        if (ld_valid) begin
          we_hi = (ptr_q[0] == HI_HALF);
          we_lo = (ptr_q[0] == LO_HALF);
          ptr_d = ptr_q + PTR_ONE;
          rem_d = rem_q - REM_ONE;
          if (rem_q == REM_ONE) state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = RST_STATE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RST_STATE;
      ptr_q   <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      rem_q   <= rem_d;
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign ld_ready  = (state_q == ST_LOAD);
  assign done      = (state_q == ST_DONE);
  assign mem_rdata = mem_re ? rdata : '0;

  instr_mem_array #(.ADDR_WIDTH(ADDR_WIDTH)) u_array (
    .clk   (clk),
    .we_hi (we_hi),
    .we_lo (we_lo),
    .waddr (waddr),
    .wdata (wdata),
    .raddr (mem_addr),
    .rdata (rdata)
  );

endmodule

// File: tb/tb_instr_mem.sv
// Directed self-checking bench for instr_mem (ADDR_WIDTH=10); covers the
// INSTR_MEM_CLEAR_EN sweep when that macro is defined.
module tb_instr_mem;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  mem_addr;
  logic        mem_re;
  logic [63:0] mem_rdata;
  logic        ld_start;
  logic [63:0] ld_base;
  logic [11:0] ld_len;
  logic        ld_valid;
  logic [31:0] ld_data;
  logic        ld_ready;
  logic        busy;
  logic        done;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] beats [4];

  always #5 clk = ~clk;

  instr_mem #(.ADDR_WIDTH(10)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mem_addr  (mem_addr),
    .mem_re    (mem_re),
    .mem_rdata (mem_rdata),
    .ld_start  (ld_start),
    .ld_base   (ld_base),
    .ld_len    (ld_len),
    .ld_valid  (ld_valid),
    .ld_data   (ld_data),
    .ld_ready  (ld_ready),
    .busy      (busy),
    .done      (done)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic rdchk(input string tag, input logic [9:0] a, input logic [63:0] exp);
    tick;
    mem_re   = 1'b1;
    mem_addr = a;
    #1;
    chk(tag, mem_rdata, exp);
  endtask

  task automatic do_load(input string tag, input logic [63:0] base, input logic [11:0] len);
    tick;
    ld_start = 1'b1;
    ld_base  = base;
    ld_len   = len;
    tick;
    ld_start = 1'b0;
    if (len == 12'd0) begin
      #1;
      chk({tag, "_zero_ready"}, {63'd0, ld_ready}, 64'd0);
      chk({tag, "_zero_done"}, {63'd0, done}, 64'd1);
      tick;
      chk({tag, "_zero_done_end"}, {63'd0, done}, 64'd0);
      chk({tag, "_zero_idle"}, {63'd0, busy}, 64'd0);
    end else begin
      for (int k = 0; k < int'(len); k++) begin
        ld_valid = 1'b1;
        ld_data  = beats[k];
        #1;
        chk({tag, "_ready"}, {63'd0, ld_ready}, 64'd1);
        chk({tag, "_no_early_done"}, {63'd0, done}, 64'd0);
        tick;
      end
      ld_valid = 1'b0;
      #1;
      chk({tag, "_done"}, {63'd0, done}, 64'd1);
      chk({tag, "_ready_drop"}, {63'd0, ld_ready}, 64'd0);
      tick;
      chk({tag, "_done_once"}, {63'd0, done}, 64'd0);
      chk({tag, "_idle"}, {63'd0, busy}, 64'd0);
    end
  endtask

  task automatic wait_clear(input string tag);
    int cnt;
    cnt = 0;
    while (busy && cnt < 2000) begin
      chk({tag, "_no_ready"}, {63'd0, ld_ready}, 64'd0);
      tick;
      cnt++;
    end
    chk({tag, "_cycles"}, 64'(cnt), 64'd1024);
  endtask

  initial begin
    rst_n    = 1'b0;
    mem_addr = '0;
    mem_re   = 1'b0;
    ld_start = 1'b0;
    ld_base  = '0;
    ld_len   = '0;
    ld_valid = 1'b0;
    ld_data  = '0;
    #12;
    chk("rst_ready", {63'd0, ld_ready}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
`ifdef INSTR_MEM_CLEAR_EN
    chk("rst_busy", {63'd0, busy}, 64'd1);
    rst_n = 1'b1;
    wait_clear("clear0");
    rdchk("clear0_w0", 10'h000, 64'h0);
    rdchk("clear0_wtop", 10'h3FF, 64'h0);
`else
    chk("rst_busy", {63'd0, busy}, 64'd0);
    rst_n = 1'b1;
`endif

    // Four beats filling words 0 and 1, with a stall before the third
    beats[0] = 32'h11111111; beats[1] = 32'hAAAAAAAA;
    beats[2] = 32'h22222222; beats[3] = 32'hBBBBBBBB;
    tick;
    ld_start = 1'b1; ld_base = 64'h0; ld_len = 12'd4;
    tick;
    ld_start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k == 2) begin
        ld_valid = 1'b0;
        tick;
        chk("l1_stall_ready", {63'd0, ld_ready}, 64'd1);
        chk("l1_stall_done", {63'd0, done}, 64'd0);
      end
      ld_valid = 1'b1;
      ld_data  = beats[k];
      #1;
      chk("l1_ready", {63'd0, ld_ready}, 64'd1);
      chk("l1_no_done", {63'd0, done}, 64'd0);
      tick;
    end
    ld_valid = 1'b0;
    #1;
    chk("l1_done", {63'd0, done}, 64'd1);
    tick;
    chk("l1_done_once", {63'd0, done}, 64'd0);
    rdchk("l1_w0", 10'h000, 64'h11111111_AAAAAAAA);
    rdchk("l1_w1", 10'h001, 64'h22222222_BBBBBBBB);

    // Preload word 0x20 then overwrite only its low half
    beats[0] = 32'h01234567; beats[1] = 32'h89ABCDEF;
    do_load("l2a", 64'h100, 12'd2);
    rdchk("l2a_w20", 10'h020, 64'h01234567_89ABCDEF);
    beats[0] = 32'hDEADBEEF;
    do_load("l2b", 64'hFFFF_0000_0000_0107, 12'd1);
    rdchk("l2b_w20", 10'h020, 64'h01234567_DEADBEEF);

    // Last index then wrap to index 0
    beats[0] = 32'hCAFEF00D; beats[1] = 32'h12345678;
    do_load("l3", 64'h1FFC, 12'd2);
    rdchk("l3_top_lo", 10'h3FF, {32'h0, mem_rdata[63:32] & 32'h0} | {32'h0, 32'hCAFEF00D});
    chk("l3_top_lo_only", {32'h0, mem_rdata[31:0]}, {32'h0, 32'hCAFEF00D});
    rdchk("l3_w0_wrap", 10'h000, 64'h12345678_AAAAAAAA);

    // Zero-length load
    do_load("l4", 64'h0, 12'd0);
    rdchk("l4_w0_same", 10'h000, 64'h12345678_AAAAAAAA);
    rdchk("l4_w1_same", 10'h001, 64'h22222222_BBBBBBBB);

    // Same-cycle read/write; ld_start during LOAD/DONE ignored
    tick;
    ld_start = 1'b1; ld_base = 64'h8; ld_len = 12'd1;
    tick;
    ld_base = 64'h0; ld_len = 12'd3;
    ld_valid = 1'b1; ld_data = 32'h55555555;
    mem_re = 1'b1; mem_addr = 10'h001;
    #1;
    chk("l5_old_data", mem_rdata, 64'h22222222_BBBBBBBB);
    tick;
    ld_valid = 1'b0;
    #1;
    chk("l5_new_data", mem_rdata, 64'h55555555_BBBBBBBB);
    chk("l5_done", {63'd0, done}, 64'd1);
    ld_start = 1'b0;
    tick;
    chk("l5_idle", {63'd0, busy}, 64'd0);
    chk("l5_no_ready", {63'd0, ld_ready}, 64'd0);
    mem_re = 1'b0;
    #1;
    chk("re_low_zero", mem_rdata, 64'h0);
    rdchk("l5_w0_same", 10'h000, 64'h12345678_AAAAAAAA);

    // ld_valid in IDLE must not write
    ld_valid = 1'b1; ld_data = 32'hFFFFFFFF;
    tick;
    tick;
    ld_valid = 1'b0;
    chk("idle_valid_busy", {63'd0, busy}, 64'd0);
    rdchk("idle_valid_w1", 10'h001, 64'h55555555_BBBBBBBB);

    // Reset after two of four beats
    tick;
    ld_start = 1'b1; ld_base = 64'h200; ld_len = 12'd4;
    tick;
    ld_start = 1'b0;
    ld_valid = 1'b1; ld_data = 32'hA0A0A0A0;
    tick;
    ld_data = 32'hA1A1A1A1;
    tick;
    ld_data = 32'hA2A2A2A2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_ready", {63'd0, ld_ready}, 64'd0);
    chk("rst_mid_done", {63'd0, done}, 64'd0);
`ifdef INSTR_MEM_CLEAR_EN
    chk("rst_mid_busy", {63'd0, busy}, 64'd1);
`else
    chk("rst_mid_busy", {63'd0, busy}, 64'd0);
`endif
    tick;
    ld_valid = 1'b0;
    rst_n = 1'b1;
`ifdef INSTR_MEM_CLEAR_EN
    wait_clear("clear1");
    chk("clear1_done", {63'd0, done}, 64'd0);
    rdchk("clear1_w0", 10'h000, 64'h0);
    rdchk("clear1_w40", 10'h040, 64'h0);
    rdchk("clear1_wtop", 10'h3FF, 64'h0);
`else
    tick;
    chk("rst_after_done", {63'd0, done}, 64'd0);
    tick;
    chk("rst_after_done2", {63'd0, done}, 64'd0);
    rdchk("rst_partial_w40", 10'h040, 64'hA0A0A0A0_A1A1A1A1);
    rdchk("rst_keep_w0", 10'h000, 64'h12345678_AAAAAAAA);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
